alu_opa_sequencer: RTL

//  Multi-cycle control FSM that schedules the single shared ALU for one issued instruction.

---
 rtl/alu_opa_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_opa_sequencer.sv
// alu_opa_sequencer
// Control FSM that schedules the single shared ALU for one issued instruction.
// Single-slot instructions finish in EXEC. JAL/JALR use LINK then TARGET.
// Branches use CMP, then TARGET only when the branch is taken.
// All outputs are decoded from the registered state and the latched opcode.
// The only exception is CMP, whose completion depends on br_taken.
module alu_opa_sequencer #(
   parameter int   OPC_W   = 7,
   parameter logic SEL_RS1 = 1'b0,
   parameter logic SEL_PC  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [OPC_W-1:0] opcode,
   input  logic             br_taken,
   input  logic             hold,
   output logic             mrs1andpc_ctr,
   output logic [1:0]       opb_sel,
   output logic [1:0]       alu_op_sel,
   output logic             imm_bypass,
   output logic             rd_we,
   output logic             pc_we,
   output logic             jalr_lsb_clr,
   output logic             mem_req,
   output logic             pc_inc,
   output logic             done,
   output logic             illegal,
   output logic [2:0]       state_o
);

   // RV32I major opcodes handled by this sequencer
   localparam logic [OPC_W-1:0] OPC_OP     = OPC_W'(7'b0110011);
   localparam logic [OPC_W-1:0] OPC_OP_IMM = OPC_W'(7'b0010011);
   localparam logic [OPC_W-1:0] OPC_LUI    = OPC_W'(7'b0110111);
   localparam logic [OPC_W-1:0] OPC_AUIPC  = OPC_W'(7'b0010111);
   localparam logic [OPC_W-1:0] OPC_LOAD   = OPC_W'(7'b0000011);
   localparam logic [OPC_W-1:0] OPC_STORE  = OPC_W'(7'b0100011);
   localparam logic [OPC_W-1:0] OPC_JAL    = OPC_W'(7'b1101111);
   localparam logic [OPC_W-1:0] OPC_JALR   = OPC_W'(7'b1100111);
   localparam logic [OPC_W-1:0] OPC_BRANCH = OPC_W'(7'b1100011);

   // Operand-B select encodings
   localparam logic [1:0] OPB_RS2  = 2'b00;
   localparam logic [1:0] OPB_IMM  = 2'b01;
   localparam logic [1:0] OPB_CST4 = 2'b10;

   // ALU operation class encodings
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EXEC   = 3'd1,
      S_LINK   = 3'd2,
      S_CMP    = 3'd3,
      S_TARGET = 3'd4,
      S_ILL    = 3'd5
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [OPC_W-1:0] opcode_q;
   logic             accept;

   // Strobes before hold/reset gating; the selects are never gated.
   logic rd_we_raw;
   logic pc_we_raw;
   logic mem_req_raw;
   logic pc_inc_raw;
   logic done_raw;
   logic illegal_raw;
   logic strobe_en;

   // First state after accepting an instruction with the given opcode.
   function automatic state_t first_state(input logic [OPC_W-1:0] opc);
      state_t s;
      unique case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE: s = S_EXEC;
         OPC_JAL, OPC_JALR:                                           s = S_LINK;
         OPC_BRANCH:                                                  s = S_CMP;
         default:                                                     s = S_ILL;
      endcase
      return s;
   endfunction

   assign issue_ready = (state_q == S_IDLE);
   assign accept      = issue_valid && issue_ready;
   assign state_o     = state_q;

   // State register and opcode latch; the opcode is captured only on accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            opcode_q <= opcode;
         end
      end
   end

   // Next-state logic; hold freezes every non-IDLE state, and IDLE ignores hold.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (issue_valid) begin
               state_d = first_state(opcode);
            end
         end
         S_EXEC: begin
            if (!hold) state_d = S_IDLE;
         end
         S_LINK: begin
            if (!hold) state_d = S_TARGET;
         end
         S_CMP: begin
            if (!hold) state_d = br_taken ? S_TARGET : S_IDLE;
         end
         S_TARGET: begin
            if (!hold) state_d = S_IDLE;
         end
         S_ILL: begin
            if (!hold) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath control decode from the registered state and the latched opcode.
   always_comb begin
      mrs1andpc_ctr = SEL_RS1;
      opb_sel       = OPB_RS2;
      alu_op_sel    = ALU_ADD;
      imm_bypass    = 1'b0;
      jalr_lsb_clr  = 1'b0;
      rd_we_raw     = 1'b0;
      pc_we_raw     = 1'b0;
      mem_req_raw   = 1'b0;
      pc_inc_raw    = 1'b0;
      done_raw      = 1'b0;
      illegal_raw   = 1'b0;
      unique case (state_q)
         S_EXEC: begin
            done_raw   = 1'b1;
            pc_inc_raw = 1'b1;
            unique case (opcode_q)
               OPC_OP: begin
                  mrs1andpc_ctr = SEL_RS1;
                  opb_sel       = OPB_RS2;
                  alu_op_sel    = ALU_FUNCT;
                  rd_we_raw     = 1'b1;
               end
               OPC_OP_IMM: begin
                  mrs1andpc_ctr = SEL_RS1;
                  opb_sel       = OPB_IMM;
                  alu_op_sel    = ALU_FUNCT;
                  rd_we_raw     = 1'b1;
               end
               OPC_AUIPC: begin
                  mrs1andpc_ctr = SEL_PC;
                  opb_sel       = OPB_IMM;
                  alu_op_sel    = ALU_ADD;
                  rd_we_raw     = 1'b1;
               end
               OPC_LUI: begin
                  imm_bypass = 1'b1;
                  rd_we_raw  = 1'b1;
               end
               OPC_LOAD, OPC_STORE: begin
                  mrs1andpc_ctr = SEL_RS1;
                  opb_sel       = OPB_IMM;
                  alu_op_sel    = ALU_ADD;
                  mem_req_raw   = 1'b1;
               end
               default: begin
               end
            endcase
         end
         S_LINK: begin
            // Link value rd = pc + 4 computed on the shared ALU.
            mrs1andpc_ctr = SEL_PC;
            opb_sel       = OPB_CST4;
            alu_op_sel    = ALU_ADD;
            rd_we_raw     = 1'b1;
         end
         S_CMP: begin
            mrs1andpc_ctr = SEL_RS1;
            opb_sel       = OPB_RS2;
            alu_op_sel    = ALU_SUB;
            if (!br_taken) begin
               done_raw   = 1'b1;
               pc_inc_raw = 1'b1;
            end
         end
         S_TARGET: begin
            opb_sel    = OPB_IMM;
            alu_op_sel = ALU_ADD;
            done_raw   = 1'b1;
            pc_we_raw  = 1'b1;
            if (opcode_q == OPC_JALR) begin
               mrs1andpc_ctr = SEL_RS1;
               jalr_lsb_clr  = 1'b1;
            end else begin
               mrs1andpc_ctr = SEL_PC;
            end
         end
         S_ILL: begin
            illegal_raw = 1'b1;
            done_raw    = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Strobes are suppressed while stalled and during the reset cycle, so a
   // stalled slot fires exactly once and an aborted instruction commits nothing.
   assign strobe_en = rst_n && !hold;
   assign rd_we     = rd_we_raw   && strobe_en;
   assign pc_we     = pc_we_raw   && strobe_en;
   assign mem_req   = mem_req_raw && strobe_en;
   assign pc_inc    = pc_inc_raw  && strobe_en;
   assign done      = done_raw    && strobe_en;
   assign illegal   = illegal_raw && strobe_en;

endmodule
